// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, mode encodings and colour-bar table
package vga_pkg;

  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 10;

  typedef enum logic [1:0] {
    MODE_EXT     = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  // {r,g,b} on/off flags per bar; callers replicate each flag to CH_W bits.
  function automatic logic [2:0] bar_mask(input logic [2:0] bar);
    logic [2:0] m;
    case (bar)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational test-pattern colour from active-area coordinates
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int CH_W   = 4,
  parameter int CW     = 11,
  parameter int RGB_W  = 3 * CH_W
) (
  input  logic [CW-1:0]    xpos,
  input  logic [CW-1:0]    ypos,
  input  mode_e            mode,
  input  logic [RGB_W-1:0] bg_color,
  output logic [RGB_W-1:0] rgb
);

  logic [2:0] bar;
  logic [2:0] mask;
  logic       in_area;

  always_comb begin
    // bar = floor(xpos*8/H_DISP) as a threshold count, avoiding a divider
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({xpos, 3'b000} >= (CW+3)'(k * H_DISP)) bar = 3'(k);
    end
    mask    = bar_mask(bar);
    in_area = (xpos < CW'(H_DISP)) && (ypos < CW'(V_DISP));

    case (mode)
      MODE_BARS:    rgb = {{CH_W{mask[2]}}, {CH_W{mask[1]}}, {CH_W{mask[0]}}};
      MODE_SOLID:   rgb = bg_color;
      MODE_CHECKER: rgb = {RGB_W{xpos[5] ^ ypos[5]}};
      default:      rgb = '0;
    endcase

    if (!in_area) rgb = '0;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator with latency-compensated pixel requests
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int PIX_LAT = 1,
  parameter int CH_W    = 4,
  parameter int CW      = 11,
  parameter int RGB_W   = 3 * CH_W
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] bg_color,
  output logic             pix_req,
  output logic [CW-1:0]    pix_xpos,
  output logic [CW-1:0]    pix_ypos,
  output logic             frame_start,
  input  logic [RGB_W-1:0] pix_data,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] HA_END = CW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CW-1:0] VA_BEG = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] VA_END = CW'(V_SYNC + V_BACK + V_DISP);
  localparam int            LAST   = PIX_LAT - 1;

  logic [CW-1:0]    cnt_h;
  logic [CW-1:0]    cnt_v;
  mode_e            mode_r;

  logic             h_act;
  logic             v_act;
  logic             hs_t;
  logic             vs_t;
  logic [RGB_W-1:0] pat_rgb;

  logic [LAST:0]    hs_d;
  logic [LAST:0]    vs_d;
  logic [LAST:0]    de_d;
  logic [LAST:0]    ext_d;
  logic [RGB_W-1:0] rgb_d [PIX_LAT];

  // Request timeline: everything here describes cycle t, ahead of the pins.
  always_comb begin
    h_act       = (cnt_h >= HA_BEG) && (cnt_h < HA_END);
    v_act       = (cnt_v >= VA_BEG) && (cnt_v < VA_END);
    pix_req     = en && h_act && v_act;
    pix_xpos    = pix_req ? (cnt_h - HA_BEG) : '0;
    pix_ypos    = pix_req ? (cnt_v - VA_BEG) : '0;
    frame_start = en && (cnt_h == '0) && (cnt_v == '0);
    hs_t        = (cnt_h < HS_END) ? HS_POL : ~HS_POL;
    vs_t        = (cnt_v < VS_END) ? VS_POL : ~VS_POL;
  end

  vga_pattern_gen #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .CH_W   (CH_W),
    .CW     (CW),
    .RGB_W  (RGB_W)
  ) u_pattern (
    .xpos     (pix_xpos),
    .ypos     (pix_ypos),
    .mode     (mode_r),
    .bg_color (bg_color),
    .rgb      (pat_rgb)
  );

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      cnt_h  <= '0;
      cnt_v  <= '0;
      mode_r <= MODE_EXT;
    end else if (!en) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      // mode only changes on a frame boundary so a frame never mixes sources
      if (frame_start) mode_r <= mode_e'(mode);
      if (cnt_h == H_LAST) begin
        cnt_h <= '0;
        cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
      end else begin
        cnt_h <= cnt_h + 1'b1;
      end
    end
  end

  // Delay line matching the source read latency.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      hs_d  <= {PIX_LAT{~HS_POL}};
      vs_d  <= {PIX_LAT{~VS_POL}};
      de_d  <= '0;
      ext_d <= '0;
      for (int k = 0; k < PIX_LAT; k++) rgb_d[k] <= '0;
    end else begin
      hs_d[0]  <= en ? hs_t : ~HS_POL;
      vs_d[0]  <= en ? vs_t : ~VS_POL;
      de_d[0]  <= pix_req;
      ext_d[0] <= en && (mode_r == MODE_EXT);
      rgb_d[0] <= en ? pat_rgb : '0;
      for (int k = 1; k < PIX_LAT; k++) begin
        hs_d[k]  <= hs_d[k-1];
        vs_d[k]  <= vs_d[k-1];
        de_d[k]  <= de_d[k-1];
        ext_d[k] <= ext_d[k-1];
        rgb_d[k] <= rgb_d[k-1];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      vga_hs  <= ~HS_POL;
      vga_vs  <= ~VS_POL;
      vga_de  <= 1'b0;
      vga_rgb <= '0;
    end else begin
      vga_hs  <= hs_d[LAST];
      vga_vs  <= vs_d[LAST];
      vga_de  <= de_d[LAST];
      vga_rgb <= !de_d[LAST] ? '0 : (ext_d[LAST] ? pix_data : rgb_d[LAST]);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int NS = 4405;
  localparam int NB = 130;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst;
  logic        en_a, en_b;
  logic [1:0]  mode_a, mode_b;
  logic [11:0] bg_a, bg_b;
  logic [11:0] pd_a = '0, pd_b = '0;
  logic        req_a, fs_a, hs_a, vs_a, de_a;
  logic        req_b, fs_b, hs_b, vs_b, de_b;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic [11:0] rgb_a, rgb_b;

  // A: 80x55 frame, active 64x48 at (14,5), PIX_LAT 2, active-low sync
  vga_timing_gen #(
    .H_SYNC(8), .H_BACK(6), .H_DISP(64), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_DISP(48), .V_FRONT(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2), .CH_W(4), .CW(11)
  ) dut_a (
    .vga_clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .bg_color(bg_a),
    .pix_req(req_a), .pix_xpos(x_a), .pix_ypos(y_a), .frame_start(fs_a),
    .pix_data(pd_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a)
  );

  // B: 10x6 frame, active 4x3 at (4,2), PIX_LAT 4, active-high sync
  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(4), .CH_W(4), .CW(11)
  ) dut_b (
    .vga_clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .bg_color(bg_b),
    .pix_req(req_b), .pix_xpos(x_b), .pix_ypos(y_b), .frame_start(fs_b),
    .pix_data(pd_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b)
  );

  // Frame sources with 2 and 4 cycles of read latency.
  logic [11:0] sa1 = '0, sb1 = '0, sb2 = '0, sb3 = '0;
  always @(posedge clk) begin
    sa1  <= req_a ? {x_a[3:0], y_a[3:0], 4'hA} : 12'h000;
    pd_a <= sa1;
    sb1  <= req_b ? {x_b[3:0], y_b[3:0], 4'h5} : 12'h000;
    sb2  <= sb1;
    sb3  <= sb2;
    pd_b <= sb3;
  end

  function automatic bit act_a(input int t);
    int h, v;
    h = t % 80;
    v = (t % 4400) / 80;
    return (v >= 5) && (v < 53) && (h >= 14) && (h < 78);
  endfunction

  function automatic logic [11:0] ext_a(input int t);
    int h, v;
    h = t % 80;
    v = (t % 4400) / 80;
    return {4'(h - 14), 4'(v - 5), 4'hA};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; bg_a = 12'h000; bg_b = 12'h000;
    repeat (3) step();
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL reset_hs_a: got %b expected 1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL reset_vs_a: got %b expected 1", vs_a); end
    checks++; if (de_a !== 1'b0) begin errors++; $display("FAIL reset_de_a: got %b expected 0", de_a); end
    checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL reset_rgb_a: got %h expected 000", rgb_a); end
    checks++; if (req_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL reset_req_fs_a: got %b%b expected 00", req_a, fs_a); end
    checks++; if (hs_b !== 1'b0 || vs_b !== 1'b0) begin errors++; $display("FAIL reset_sync_b: got %b%b expected 00", hs_b, vs_b); end
  endtask

  task automatic test_sync();
    logic        hs_h [NS];
    logic        vs_h [NS];
    logic        de_h [NS];
    logic        req_h [NS];
    logic        fs_h [NS];
    logic [10:0] x_h [NS];
    logic [10:0] y_h [NS];
    logic [11:0] rgb_h [NS];
    int lo_hs = 0, lo_vs = 0, n_req = 0, n_de = 0, n_fs = 0;
    int bad_req = 0, bad_pos = 0, bad_de = 0, bad_rgb = 0, first = -1, last = -1;
    bit e;
    logic [11:0] er;
    rst = 1'b1; en_a = 1'b1; #1;
    for (int n = 0; n < NS; n++) begin
      hs_h[n] = hs_a; vs_h[n] = vs_a; de_h[n] = de_a; req_h[n] = req_a;
      fs_h[n] = fs_a; x_h[n] = x_a; y_h[n] = y_a; rgb_h[n] = rgb_a;
      step();
    end
    for (int n = 0; n < 4400; n++) begin
      e  = act_a(n);
      er = e ? ext_a(n) : 12'h000;
      if (req_h[n] !== e) bad_req++;
      if (req_h[n] === 1'b1) begin n_req++; if (first < 0) first = n; last = n; end
      if (x_h[n] !== (e ? 11'(n % 80 - 14) : 11'd0) || y_h[n] !== (e ? 11'(n / 80 - 5) : 11'd0)) bad_pos++;
      if (de_h[n+3] !== e) bad_de++;
      if (de_h[n+3] === 1'b1) n_de++;
      if (rgb_h[n+3] !== er) bad_rgb++;
      if (hs_h[n+3] === 1'b0) lo_hs++;
      if (vs_h[n+3] === 1'b0) lo_vs++;
    end
    for (int n = 0; n <= 4400; n++) if (fs_h[n] === 1'b1) n_fs++;
    checks++; if (hs_h[2] !== 1'b1) begin errors++; $display("FAIL sync_hs_idle_c2: got %b expected 1", hs_h[2]); end
    checks++; if (hs_h[3] !== 1'b0) begin errors++; $display("FAIL sync_hs_first_c3: got %b expected 0", hs_h[3]); end
    checks++; if (hs_h[11] !== 1'b1) begin errors++; $display("FAIL sync_hs_end_c11: got %b expected 1", hs_h[11]); end
    checks++; if (lo_hs != 440) begin errors++; $display("FAIL sync_hs_low_count: got %0d expected 440", lo_hs); end
    checks++; if (lo_vs != 160) begin errors++; $display("FAIL sync_vs_low_count: got %0d expected 160", lo_vs); end
    checks++; if (bad_req != 0) begin errors++; $display("FAIL sync_req_timeline: got %0d bad cycles expected 0", bad_req); end
    checks++; if (bad_pos != 0) begin errors++; $display("FAIL sync_xy_pos: got %0d bad cycles expected 0", bad_pos); end
    checks++; if (bad_de != 0) begin errors++; $display("FAIL sync_de_latency: got %0d bad cycles expected 0", bad_de); end
    checks++; if (bad_rgb != 0) begin errors++; $display("FAIL sync_ext_rgb: got %0d bad cycles expected 0", bad_rgb); end
    checks++; if (n_req != 3072) begin errors++; $display("FAIL sync_req_count: got %0d expected 3072", n_req); end
    checks++; if (n_de != 3072) begin errors++; $display("FAIL sync_de_count: got %0d expected 3072", n_de); end
    checks++; if (first != 414) begin errors++; $display("FAIL sync_first_req: got %0d expected 414", first); end
    checks++; if (last != 4237) begin errors++; $display("FAIL sync_last_req: got %0d expected 4237", last); end
    checks++; if (n_fs != 2 || fs_h[4400] !== 1'b1) begin errors++; $display("FAIL sync_frame_start: got %0d pulses expected 2 at 0 and 4400", n_fs); end
  endtask

  task automatic test_enable();
    int bad = 0, found = -1;
    logic [10:0] fx = '1, fy = '1;
    repeat (1000) step();
    en_a = 1'b0; #1;
    checks++; if (req_a !== 1'b0 || fs_a !== 1'b0) begin errors++; $display("FAIL en_low_req_fs: got %b%b expected 00", req_a, fs_a); end
    for (int n = 0; n < 100; n++) begin
      if (req_a !== 1'b0 || fs_a !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_low_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (hs_a !== 1'b1 || de_a !== 1'b0 || rgb_a !== 12'h000) begin errors++; $display("FAIL en_low_idle_out: got hs=%b de=%b rgb=%h expected 1 0 000", hs_a, de_a, rgb_a); end
    en_a = 1'b1; #1;
    checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL en_restart_fs: got %b expected 1", fs_a); end
    for (int n = 0; n < 2000; n++) begin
      if (req_a === 1'b1) begin found = n; fx = x_a; fy = y_a; break; end
      step();
    end
    checks++; if (found != 414) begin errors++; $display("FAIL en_restart_first_req: got %0d expected 414", found); end
    checks++; if (fx !== 11'd0 || fy !== 11'd0) begin errors++; $display("FAIL en_restart_xy: got %0d,%0d expected 0,0", fx, fy); end
  endtask

  task automatic test_bars();
    logic [11:0] rgb_h [481];
    int          xs [10] = '{0, 7, 8, 16, 24, 32, 40, 48, 56, 63};
    logic [11:0] cs [10] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000, 12'h000};
    en_a = 1'b0; step();
    mode_a = 2'd1; en_a = 1'b1; #1;
    for (int n = 0; n < 481; n++) begin
      rgb_h[n] = rgb_a;
      step();
    end
    checks++; if (rgb_h[416] !== 12'h000) begin errors++; $display("FAIL bars_blank: got %h expected 000", rgb_h[416]); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rgb_h[417 + xs[i]] !== cs[i]) begin
        errors++; $display("FAIL bars_x%0d: got %h expected %h", xs[i], rgb_h[417 + xs[i]], cs[i]);
      end
    end
  endtask

  task automatic test_mode_switch();
    int bad1 = 0, bad2 = 0, t;
    bit e;
    en_a = 1'b0; step();
    mode_a = 2'd0; bg_a = 12'h0F0; en_a = 1'b1; #1;
    for (int n = 0; n < 8645; n++) begin
      if (n == 2000) mode_a = 2'd2;
      if (n >= 2003 && n < 4403) begin
        t = n - 3; e = act_a(t);
        if (de_a !== e || rgb_a !== (e ? ext_a(t) : 12'h000)) bad1++;
      end
      if (n >= 4403) begin
        t = n - 4403; e = act_a(t);
        if (de_a !== e || rgb_a !== (e ? 12'h0F0 : 12'h000)) bad2++;
      end
      if (n == 2822) begin
        checks++; if (rgb_a !== 12'h5EA) begin errors++; $display("FAIL switch_still_ext: got %h expected 5ea", rgb_a); end
      end
      if (n == 4817) begin
        checks++; if (rgb_a !== 12'h0F0) begin errors++; $display("FAIL switch_next_solid: got %h expected 0f0", rgb_a); end
      end
      step();
    end
    checks++; if (bad1 != 0) begin errors++; $display("FAIL switch_rest_of_frame: got %0d bad cycles expected 0", bad1); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL switch_solid_frame: got %0d bad cycles expected 0", bad2); end
  endtask

  task automatic test_checker_and_reset();
    en_a = 1'b0; step();
    mode_a = 2'd3; en_a = 1'b1; #1;
    for (int n = 0; n < 3010; n++) begin
      if (n == 417) begin checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL chk_r0_x0: got %h expected 000", rgb_a); end end
      if (n == 449) begin checks++; if (rgb_a !== 12'hFFF) begin errors++; $display("FAIL chk_r0_x32: got %h expected fff", rgb_a); end end
      if (n == 2977) begin checks++; if (rgb_a !== 12'hFFF) begin errors++; $display("FAIL chk_r32_x0: got %h expected fff", rgb_a); end end
      if (n == 3009) begin checks++; if (rgb_a !== 12'h000) begin errors++; $display("FAIL chk_r32_x32: got %h expected 000", rgb_a); end end
      step();
    end
    checks++; if (de_a !== 1'b1) begin errors++; $display("FAIL areset_pre_de: got %b expected 1", de_a); end
    #2 rst = 1'b0;
    #1;
    checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin errors++; $display("FAIL areset_sync: got %b%b expected 11", hs_a, vs_a); end
    checks++; if (de_a !== 1'b0 || rgb_a !== 12'h000) begin errors++; $display("FAIL areset_de_rgb: got de=%b rgb=%h expected 0 000", de_a, rgb_a); end
    checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL areset_req: got %b expected 0", req_a); end
    en_a = 1'b0; mode_a = 2'd0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_small();
    logic        hs_h [NB];
    logic        vs_h [NB];
    logic        de_h [NB];
    logic        req_h [NB];
    logic        fs_h [NB];
    logic [10:0] x_h [NB];
    logic [10:0] y_h [NB];
    logic [11:0] rgb_h [NB];
    int hi_hs = 0, hi_vs = 0, n_req = 0, n_de = 0, n_fs = 0, first = -1, last = -1;
    en_b = 1'b1; #1;
    for (int n = 0; n < NB; n++) begin
      hs_h[n] = hs_b; vs_h[n] = vs_b; de_h[n] = de_b; req_h[n] = req_b;
      fs_h[n] = fs_b; x_h[n] = x_b; y_h[n] = y_b; rgb_h[n] = rgb_b;
      step();
    end
    for (int n = 0; n < 60; n++) begin
      if (hs_h[n+5] === 1'b1) hi_hs++;
      if (vs_h[n+5] === 1'b1) hi_vs++;
      if (de_h[n+5] === 1'b1) n_de++;
      if (req_h[n] === 1'b1) begin n_req++; if (first < 0) first = n; last = n; end
    end
    for (int n = 0; n < 120; n++) if (fs_h[n] === 1'b1) n_fs++;
    checks++; if (hs_h[4] !== 1'b0 || hs_h[5] !== 1'b1 || hs_h[6] !== 1'b1 || hs_h[7] !== 1'b0) begin errors++; $display("FAIL small_hs_c4to7: got %b%b%b%b expected 0110", hs_h[4], hs_h[5], hs_h[6], hs_h[7]); end
    checks++; if (hs_h[14] !== 1'b0 || hs_h[15] !== 1'b1) begin errors++; $display("FAIL small_line_period: got %b%b expected 01", hs_h[14], hs_h[15]); end
    checks++; if (hi_hs != 12) begin errors++; $display("FAIL small_hs_count: got %0d expected 12", hi_hs); end
    checks++; if (hi_vs != 10) begin errors++; $display("FAIL small_vs_count: got %0d expected 10", hi_vs); end
    checks++; if (n_req != 12) begin errors++; $display("FAIL small_req_count: got %0d expected 12", n_req); end
    checks++; if (n_de != 12) begin errors++; $display("FAIL small_de_count: got %0d expected 12", n_de); end
    checks++; if (first != 24 || last != 47) begin errors++; $display("FAIL small_req_span: got %0d..%0d expected 24..47", first, last); end
    checks++; if (x_h[47] !== 11'd3 || y_h[47] !== 11'd2) begin errors++; $display("FAIL small_last_xy: got %0d,%0d expected 3,2", x_h[47], y_h[47]); end
    checks++; if (de_h[29] !== 1'b1 || rgb_h[29] !== 12'h005) begin errors++; $display("FAIL small_first_px: got de=%b rgb=%h expected 1 005", de_h[29], rgb_h[29]); end
    checks++; if (de_h[52] !== 1'b1 || rgb_h[52] !== 12'h325) begin errors++; $display("FAIL small_last_px: got de=%b rgb=%h expected 1 325", de_h[52], rgb_h[52]); end
    checks++; if (de_h[53] !== 1'b0 || rgb_h[53] !== 12'h000) begin errors++; $display("FAIL small_after_px: got de=%b rgb=%h expected 0 000", de_h[53], rgb_h[53]); end
    checks++; if (n_fs != 2 || fs_h[60] !== 1'b1) begin errors++; $display("FAIL small_frame_wrap: got %0d pulses expected 2 at 0 and 60", n_fs); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_enable();
    test_bars();
    test_mode_switch();
    test_checker_and_reset();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
